ipark_tr: RTL and testbench



---
 rtl/ipark_tr.sv | 277 +++++++++++++++++++++++++++
 tb/tb_ipark_tr.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ipark_tr.sv
// Inverse Park transform: (vd, vq) rotated by theta into (valpha, vbeta).
// One shared 16x16 signed multiplier is sequenced over four cycles; sin/cos come
// from an iterative CORDIC lookup with an o_en handshake and Q14 outputs.

module ipark_sincos (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_en,
  input  logic [11:0]        i_theta,
  output logic               o_en,
  output logic signed [15:0] o_sin,
  output logic signed [15:0] o_cos
);

  localparam int unsigned   Iters  = 20;
  // CORDIC gain 0.6072529 in Q22; x/y carry 8 guard bits over Q14.
  localparam logic signed [31:0] XInit  = 32'sd2547003;
  // (pi/2)/1024 rad in Q28: one theta LSB within a quadrant.
  localparam logic [31:0]        ZStep  = 32'd411775;

  // atan(2^-i) in Q28 radians
  function automatic logic signed [31:0] atan_lut(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_lut = 32'sd210828714;
      5'd1:    atan_lut = 32'sd124459459;
      5'd2:    atan_lut = 32'sd65760959;
      5'd3:    atan_lut = 32'sd33381290;
      5'd4:    atan_lut = 32'sd16755423;
      5'd5:    atan_lut = 32'sd8385879;
      5'd6:    atan_lut = 32'sd4193963;
      5'd7:    atan_lut = 32'sd2097109;
      5'd8:    atan_lut = 32'sd1048571;
      5'd9:    atan_lut = 32'sd524287;
      5'd10:   atan_lut = 32'sd262144;
      5'd11:   atan_lut = 32'sd131072;
      5'd12:   atan_lut = 32'sd65536;
      5'd13:   atan_lut = 32'sd32768;
      5'd14:   atan_lut = 32'sd16384;
      5'd15:   atan_lut = 32'sd8192;
      5'd16:   atan_lut = 32'sd4096;
      5'd17:   atan_lut = 32'sd2048;
      5'd18:   atan_lut = 32'sd1024;
      5'd19:   atan_lut = 32'sd512;
      default: atan_lut = 32'sd0;
    endcase
  endfunction

  logic signed [31:0] x_q, y_q, z_q;
  logic signed [31:0] x_d, y_d, z_d;
  logic [1:0]         quad_q;
  logic [4:0]         cnt_q;
  logic               run_q, fin_q;
  logic [31:0]        z_load;
  logic signed [31:0] x_rnd, y_rnd;
  logic signed [15:0] c16, s16, sin_map, cos_map;

  assign z_load = {22'd0, i_theta[9:0]} * ZStep;

  // One rotation step: drive the residual angle z toward zero
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    if (!z_q[31]) begin
      x_d = x_q - (y_q >>> cnt_q);
      y_d = y_q + (x_q >>> cnt_q);
      z_d = z_q - atan_lut(cnt_q);
    end else begin
      x_d = x_q + (y_q >>> cnt_q);
      y_d = y_q - (x_q >>> cnt_q);
      z_d = z_q + atan_lut(cnt_q);
    end
  end

  // Round the first-quadrant result to Q14 and unfold it into the full circle
  always_comb begin
    x_rnd = (x_q + 32'sd128) >>> 8;
    y_rnd = (y_q + 32'sd128) >>> 8;
    c16   = x_rnd[15:0];
    s16   = y_rnd[15:0];
    cos_map = c16;
    sin_map = s16;
    case (quad_q)
      2'd1:    begin cos_map = -s16; sin_map = c16;  end
      2'd2:    begin cos_map = -c16; sin_map = -s16; end
      2'd3:    begin cos_map = s16;  sin_map = -c16; end
      default: begin cos_map = c16;  sin_map = s16;  end
    endcase
  end

  // Load on request, iterate, then publish one o_en pulse with the result
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      quad_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      fin_q  <= 1'b0;
      o_en   <= 1'b0;
      o_sin  <= '0;
      o_cos  <= '0;
    end else begin
      o_en <= 1'b0;
      if (i_en) begin
        x_q    <= XInit;
        y_q    <= '0;
        z_q    <= signed'(z_load);
        quad_q <= i_theta[11:10];
        cnt_q  <= '0;
        run_q  <= 1'b1;
        fin_q  <= 1'b0;
      end else if (run_q) begin
        x_q   <= x_d;
        y_q   <= y_d;
        z_q   <= z_d;
        cnt_q <= cnt_q + 5'd1;
        if (cnt_q == 5'(Iters - 1)) begin
          run_q <= 1'b0;
          fin_q <= 1'b1;
        end
      end else if (fin_q) begin
        fin_q <= 1'b0;
        o_en  <= 1'b1;
        o_sin <= sin_map;
        o_cos <= cos_map;
      end
    end
  end

endmodule

module ipark_tr #(
  parameter int unsigned OUT_SHIFT = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic [11:0]        i_theta,
  input  logic signed [15:0] i_vd,
  input  logic signed [15:0] i_vq,
  output logic               o_busy,
  output logic               o_drop,
  output logic               o_en,
  output logic signed [15:0] o_valpha,
  output logic signed [15:0] o_vbeta
);

  typedef enum logic [2:0] {
    StIdle, StWaitSc, StMul0, StMul1, StMul2, StMul3, StDone
  } state_t;

  localparam logic signed [32:0] Rnd = 33'sd1 <<< (OUT_SHIFT - 1);

  state_t             state_q, state_d;
  logic signed [15:0] vd_q, vq_q, sin_q, cos_q;
  logic signed [32:0] acc_a_q, acc_b_q;
  logic signed [15:0] valpha_q, vbeta_q;
  logic               en_q, drop_q;
  logic               accept;
  logic               sc_en;
  logic signed [15:0] sc_sin, sc_cos;
  logic signed [15:0] mul_a, mul_b;
  logic signed [31:0] prod;
  logic signed [32:0] prod_ext;

  // Round half up, shift back to unity gain and clip to 16 bits
  function automatic logic signed [15:0] sat_round(input logic signed [32:0] acc);
    logic signed [32:0] r;
    r = (acc + Rnd) >>> OUT_SHIFT;
    if (r > 33'sd32767)       sat_round = 16'sh7fff;
    else if (r < -33'sd32768) sat_round = 16'sh8000;
    else                      sat_round = r[15:0];
  endfunction

  assign accept = i_en && (state_q == StIdle);

  ipark_sincos u_sincos (
    .clk     (clk),
    .rstn    (~rst),
    .i_en    (accept),
    .i_theta (i_theta),
    .o_en    (sc_en),
    .o_sin   (sc_sin),
    .o_cos   (sc_cos)
  );

  // Operand select for the shared multiplier
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      StMul0:  begin mul_a = vd_q; mul_b = cos_q; end
      StMul1:  begin mul_a = vq_q; mul_b = sin_q; end
      StMul2:  begin mul_a = vd_q; mul_b = sin_q; end
      StMul3:  begin mul_a = vq_q; mul_b = cos_q; end
      default: ;
    endcase
  end

  assign prod     = 32'(mul_a) * 32'(mul_b);
  assign prod_ext = 33'(prod);

  // Next-state sequencing; the lookup wait is handshake-driven, not counted
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (i_en) state_d = StWaitSc;
      StWaitSc: if (sc_en) state_d = StMul0;
      StMul0:   state_d = StMul1;
      StMul1:   state_d = StMul2;
      StMul2:   state_d = StMul3;
      StMul3:   state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Operand capture, accumulation and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vd_q     <= '0;
      vq_q     <= '0;
      sin_q    <= '0;
      cos_q    <= '0;
      acc_a_q  <= '0;
      acc_b_q  <= '0;
      valpha_q <= '0;
      vbeta_q  <= '0;
      en_q     <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      en_q   <= 1'b0;
      drop_q <= i_en && (state_q != StIdle);
      case (state_q)
        StIdle: begin
          if (i_en) begin
            vd_q <= i_vd;
            vq_q <= i_vq;
          end
        end
        StWaitSc: begin
          if (sc_en) begin
            sin_q   <= sc_sin;
            cos_q   <= sc_cos;
            acc_a_q <= '0;
            acc_b_q <= '0;
          end
        end
        StMul0:  acc_a_q <= acc_a_q + prod_ext;
        StMul1:  acc_a_q <= acc_a_q - prod_ext;
        StMul2:  acc_b_q <= acc_b_q + prod_ext;
        StMul3:  acc_b_q <= acc_b_q + prod_ext;
        StDone: begin
          valpha_q <= sat_round(acc_a_q);
          vbeta_q  <= sat_round(acc_b_q);
          en_q     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy   = (state_q != StIdle);
  assign o_drop   = drop_q;
  assign o_en     = en_q;
  assign o_valpha = valpha_q;
  assign o_vbeta  = vbeta_q;

endmodule

// File: tb/tb_ipark_tr.sv
// Randomized and directed bench for ipark_tr against a real-arithmetic model.
module tb_ipark_tr;

  // Clock edges from the edge sampling the lookup request to the edge raising its o_en
  localparam int SC_LAT = 21;
  localparam int PERIOD = SC_LAT + 7;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               i_en = 1'b0;
  logic [11:0]        i_theta = '0;
  logic signed [15:0] i_vd = '0;
  logic signed [15:0] i_vq = '0;
  logic               o_busy, o_drop, o_en;
  logic signed [15:0] o_valpha, o_vbeta;

  int errors = 0;
  int checks = 0;

  ipark_tr dut (
    .clk      (clk),
    .rst      (rst),
    .i_en     (i_en),
    .i_theta  (i_theta),
    .i_vd     (i_vd),
    .i_vq     (i_vq),
    .o_busy   (o_busy),
    .o_drop   (o_drop),
    .o_en     (o_en),
    .o_valpha (o_valpha),
    .o_vbeta  (o_vbeta)
  );

  always #5 clk = ~clk;

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Ideal Q14 sin/cos, exact integer products, round-half-up then clip
  task automatic model(input int th, input int vd, input int vq, output int va, output int vb);
    real ang;
    longint c, s, aa, ab;
    ang = 2.0 * 3.14159265358979 * real'(th) / 4096.0;
    c   = longint'(rnd(16384.0 * $cos(ang)));
    s   = longint'(rnd(16384.0 * $sin(ang)));
    aa  = longint'(vd) * c - longint'(vq) * s;
    ab  = longint'(vd) * s + longint'(vq) * c;
    va  = sat16((aa + 8192) >>> 14);
    vb  = sat16((ab + 8192) >>> 14);
  endtask

  // Issue one request at the current negedge and wait for its o_en.
  // Extra strobes are injected n cycles after the request when n == s1 or s2.
  task automatic transact(input int th, input int vd, input int vq, input int s1, input int s2,
                          output int n, output int drops, output logic busy1,
                          output logic busy_en, output logic hold_ok);
    logic signed [15:0] a0, b0;
    i_en = 1'b1; i_theta = 12'(th); i_vd = 16'(vd); i_vq = 16'(vq);
    a0 = o_valpha; b0 = o_vbeta;
    n = 0; drops = 0; busy1 = 1'b0; busy_en = 1'b1; hold_ok = 1'b1;
    while (n < 200) begin
      @(negedge clk);
      n++;
      i_en = 1'b0;
      if (o_drop) drops++;
      if (n == 1) busy1 = o_busy;
      if (o_en) begin
        busy_en = o_busy;
        break;
      end
      if (o_valpha !== a0 || o_vbeta !== b0) hold_ok = 1'b0;
      if (n == s1 || n == s2) begin
        i_en = 1'b1; i_theta = 12'($urandom); i_vd = 16'($urandom); i_vq = 16'($urandom);
      end
    end
    if (!o_en) n = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (o_valpha !== 16'sd0) begin errors++; $display("FAIL reset_valpha: got %0d want 0", o_valpha); end
    checks++; if (o_vbeta !== 16'sd0) begin errors++; $display("FAIL reset_vbeta: got %0d want 0", o_vbeta); end
    checks++; if (o_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", o_en); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    checks++; if (o_drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b want 0", o_drop); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    int th [6] = '{0, 1024, 2048, 512, 512, 3072};
    int vd [6] = '{1000, 1000, -32768, 20000, 32767, -32768};
    int vq [6] = '{0, 500, 0, 20000, 32767, -32768};
    int ea [6] = '{1000, -500, 32767, 0, 0, -32768};
    int eb [6] = '{0, 1000, 0, 28284, 32767, 32767};
    int ta [6] = '{0, 0, 0, 1, 1, 0};
    int tb [6] = '{0, 0, 1, 2, 0, 0};
    int n, drops, da, db;
    logic busy1, busy_en, hold_ok;
    for (int i = 0; i < 6; i++) begin
      transact(th[i], vd[i], vq[i], 0, 0, n, drops, busy1, busy_en, hold_ok);
      da = int'(o_valpha) - ea[i]; if (da < 0) da = -da;
      db = int'(o_vbeta) - eb[i];  if (db < 0) db = -db;
      checks++; if (n != PERIOD) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, n, PERIOD); end
      checks++; if (da > ta[i]) begin errors++; $display("FAIL dir%0d_valpha: got %0d want %0d+/-%0d", i, o_valpha, ea[i], ta[i]); end
      checks++; if (db > tb[i]) begin errors++; $display("FAIL dir%0d_vbeta: got %0d want %0d+/-%0d", i, o_vbeta, eb[i], tb[i]); end
      checks++; if (busy_en !== 1'b0) begin errors++; $display("FAIL dir%0d_busy_at_en: got %b want 0", i, busy_en); end
      checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL dir%0d_busy_rise: got %b want 1", i, busy1); end
      @(negedge clk);
      checks++; if (o_en !== 1'b0) begin errors++; $display("FAIL dir%0d_en_width: got %b want 0", i, o_en); end
    end
  endtask

  task automatic test_random;
    int th, vd, vq, va, vb, n, drops, da, db;
    logic busy1, busy_en, hold_ok;
    for (int i = 0; i < 16; i++) begin
      th = int'($urandom_range(0, 4095));
      vd = (i % 4 == 1) ? -32768 : int'(16'sh0 + $signed(16'($urandom)));
      vq = (i % 4 == 2) ? -32768 : int'(16'sh0 + $signed(16'($urandom)));
      model(th, vd, vq, va, vb);
      transact(th, vd, vq, 0, 0, n, drops, busy1, busy_en, hold_ok);
      da = int'(o_valpha) - va; if (da < 0) da = -da;
      db = int'(o_vbeta) - vb;  if (db < 0) db = -db;
      checks++; if (n != PERIOD) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, n, PERIOD); end
      checks++; if (da > 5) begin errors++; $display("FAIL rnd%0d_valpha th=%0d vd=%0d vq=%0d: got %0d want %0d", i, th, vd, vq, o_valpha, va); end
      checks++; if (db > 5) begin errors++; $display("FAIL rnd%0d_vbeta th=%0d vd=%0d vq=%0d: got %0d want %0d", i, th, vd, vq, o_vbeta, vb); end
      checks++; if (!hold_ok) begin errors++; $display("FAIL rnd%0d_hold: got changed want held", i); end
      repeat (i % 3) @(negedge clk);
    end
  endtask

  task automatic test_drop;
    int va, vb, n, drops, da, db;
    logic busy1, busy_en, hold_ok;
    model(300, 12000, -7000, va, vb);
    transact(300, 12000, -7000, 2, 5, n, drops, busy1, busy_en, hold_ok);
    da = int'(o_valpha) - va; if (da < 0) da = -da;
    db = int'(o_vbeta) - vb;  if (db < 0) db = -db;
    checks++; if (drops != 2) begin errors++; $display("FAIL drop_count: got %0d want 2", drops); end
    checks++; if (n != PERIOD) begin errors++; $display("FAIL drop_latency: got %0d want %0d", n, PERIOD); end
    checks++; if (da > 5) begin errors++; $display("FAIL drop_valpha: got %0d want %0d", o_valpha, va); end
    checks++; if (db > 5) begin errors++; $display("FAIL drop_vbeta: got %0d want %0d", o_vbeta, vb); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int va, vb, n, drops, da, db;
    logic busy1, busy_en, hold_ok;
    transact(1500, -20000, 9000, 0, 0, n, drops, busy1, busy_en, hold_ok);
    model(3900, 25000, 31000, va, vb);
    // Issued in the o_en cycle of the previous request
    transact(3900, 25000, 31000, 0, 0, n, drops, busy1, busy_en, hold_ok);
    da = int'(o_valpha) - va; if (da < 0) da = -da;
    db = int'(o_vbeta) - vb;  if (db < 0) db = -db;
    checks++; if (n != PERIOD) begin errors++; $display("FAIL b2b_period: got %0d want %0d", n, PERIOD); end
    checks++; if (drops != 0) begin errors++; $display("FAIL b2b_drop: got %0d want 0", drops); end
    checks++; if (!hold_ok) begin errors++; $display("FAIL b2b_hold: got changed want held"); end
    checks++; if (da > 5) begin errors++; $display("FAIL b2b_valpha: got %0d want %0d", o_valpha, va); end
    checks++; if (db > 5) begin errors++; $display("FAIL b2b_vbeta: got %0d want %0d", o_vbeta, vb); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int va, vb, n, drops, da, db, ens;
    logic busy1, busy_en, hold_ok;
    transact(700, 12000, -9000, 0, 0, n, drops, busy1, busy_en, hold_ok);
    @(negedge clk);
    i_en = 1'b1; i_theta = 12'd1800; i_vd = 16'sd15000; i_vq = 16'sd4000;
    // Lookup o_en in cycle 22, MUL0..MUL2 in cycles 23..25
    for (int k = 1; k <= SC_LAT + 4; k++) begin
      @(negedge clk);
      i_en = 1'b0;
    end
    rst = 1'b1;
    #1;
    checks++; if (o_valpha !== 16'sd0) begin errors++; $display("FAIL midrst_valpha: got %0d want 0", o_valpha); end
    checks++; if (o_vbeta !== 16'sd0) begin errors++; $display("FAIL midrst_vbeta: got %0d want 0", o_vbeta); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", o_busy); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ens = 0;
    repeat (50) begin
      @(negedge clk);
      if (o_en) ens++;
    end
    checks++; if (ens != 0) begin errors++; $display("FAIL midrst_stale_en: got %0d want 0", ens); end
    model(2500, -18000, 22000, va, vb);
    transact(2500, -18000, 22000, 0, 0, n, drops, busy1, busy_en, hold_ok);
    da = int'(o_valpha) - va; if (da < 0) da = -da;
    db = int'(o_vbeta) - vb;  if (db < 0) db = -db;
    checks++; if (n != PERIOD) begin errors++; $display("FAIL midrst_fresh_latency: got %0d want %0d", n, PERIOD); end
    checks++; if (da > 5) begin errors++; $display("FAIL midrst_fresh_valpha: got %0d want %0d", o_valpha, va); end
    checks++; if (db > 5) begin errors++; $display("FAIL midrst_fresh_vbeta: got %0d want %0d", o_vbeta, vb); end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_directed;
    test_random;
    test_drop;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
